// File: rtl/mpu_operand_feeder_if.sv
// Handshake and data bundle between the MPU operand feeder and its neighbours.
// master drives the C-row / A-B pair inputs; slave is the feeder itself.
interface mpu_operand_feeder_if #(
  parameter int DW = 64
);
  logic          c_in_valid;
  logic          c_in_ready;
  logic [DW-1:0] c_in_data;
  logic          ab_in_valid;
  logic          ab_in_ready;
  logic [DW-1:0] ab_in_a;
  logic [DW-1:0] ab_in_b;
  logic          c_valid;
  logic          c_row_vld;
  logic [DW-1:0] c_row;
  logic          ab_valid;
  logic [DW-1:0] a_out;
  logic [DW-1:0] b_out;
  logic          busy;

  modport master (
    output c_in_valid, c_in_data, ab_in_valid, ab_in_a, ab_in_b,
    input  c_in_ready, ab_in_ready, c_valid, c_row_vld, c_row,
           ab_valid, a_out, b_out, busy
  );

  modport slave (
    input  c_in_valid, c_in_data, ab_in_valid, ab_in_a, ab_in_b,
    output c_in_ready, ab_in_ready, c_valid, c_row_vld, c_row,
           ab_valid, a_out, b_out, busy
  );
endinterface

// File: rtl/mpu_operand_feeder.sv
// Buffers one C tile and replays it as a preload, then streams A/B operand pairs
// from a small FIFO, never mixing a C load with accumulate cycles.
//
//   state | meaning
//   FILL  | collecting ML C rows into rowbuf
//   SHIFT | c_valid pulse, then ML cycles replaying rowbuf
//   RUN   | accepting and issuing A/B pairs
module mpu_operand_feeder #(
  parameter int ML  = 2,
  parameter int DW  = 64,
  parameter int ABD = 4
) (
  input logic                  clk,
  input logic                  reset,
  mpu_operand_feeder_if.slave  bus
);
  localparam int CW  = $clog2(ML + 1);
  localparam int RIW = (ML > 1) ? $clog2(ML) : 1;
  localparam int PW  = $clog2(ABD) + 1;
  localparam int AW  = PW - 1;

  typedef enum logic [1:0] {FILL, SHIFT, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] rowbuf [2**RIW];
  logic [DW-1:0] a_mem [ABD];
  logic [DW-1:0] b_mem [ABD];
  logic [PW-1:0] wr_ptr, rd_ptr, count, count_nxt;
  logic          fifo_empty, fifo_full;
  logic          push, pop, row_wr;
  logic          c_valid_nxt, c_row_vld_nxt;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count_nxt  = count + PW'(push) - PW'(pop);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    row_wr        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    c_valid_nxt   = 1'b0;
    c_row_vld_nxt = 1'b0;
    case (state)
      FILL: begin
        if (bus.c_in_valid && bus.c_in_ready) begin
          row_wr = 1'b1;
          if (cnt == CW'(ML - 1)) begin
            cnt_nxt     = '0;
            state_nxt   = SHIFT;
            c_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      SHIFT: begin
        if (cnt == CW'(ML)) begin
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          c_row_vld_nxt = 1'b1;
          cnt_nxt       = cnt + CW'(1);
        end
      end
      RUN: begin
        push = bus.ab_in_valid && bus.ab_in_ready;
        pop  = !fifo_empty;
        // A pending A/B offer wins over a new tile; wait for the last pop to drain too.
        if (fifo_empty && !bus.ab_valid && bus.c_in_valid && !bus.ab_in_valid)
          state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= FILL;
      cnt             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.c_in_ready  <= 1'b1;
      bus.ab_in_ready <= 1'b0;
      bus.c_valid     <= 1'b0;
      bus.c_row_vld   <= 1'b0;
      bus.c_row       <= '0;
      bus.ab_valid    <= 1'b0;
      bus.a_out       <= '0;
      bus.b_out       <= '0;
      bus.busy        <= 1'b1;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      bus.c_in_ready  <= (state_nxt == FILL);
      bus.ab_in_ready <= (state_nxt == RUN) && (count_nxt < PW'(ABD));
      bus.c_valid     <= c_valid_nxt;
      bus.c_row_vld   <= c_row_vld_nxt;
      if (c_row_vld_nxt) bus.c_row <= rowbuf[cnt[RIW-1:0]];
      bus.ab_valid    <= pop;
      if (pop) begin
        bus.a_out <= a_mem[rd_ptr[AW-1:0]];
        bus.b_out <= b_mem[rd_ptr[AW-1:0]];
      end
      bus.busy        <= (state_nxt != RUN) || (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (row_wr) rowbuf[cnt[RIW-1:0]] <= bus.c_in_data;
    if (push) begin
      a_mem[wr_ptr[AW-1:0]] <= bus.ab_in_a;
      b_mem[wr_ptr[AW-1:0]] <= bus.ab_in_b;
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && fifo_empty));
endmodule

// File: tb/tb_mpu_operand_feeder.sv
// Randomized bench for mpu_operand_feeder: a queue/occupancy reference model
// predicts tile replay, pair ordering, ready and busy cycle by cycle.
module tb_mpu_operand_feeder;
  localparam int ML  = 2;
  localparam int DW  = 64;
  localparam int ABD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mpu_operand_feeder_if #(.DW(DW)) bus ();

  mpu_operand_feeder #(.ML(ML), .DW(DW), .ABD(ABD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.c_in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.ab_in_ready !== 1'b0 ||
        bus.c_valid !== 1'b0 || bus.c_row_vld !== 1'b0 || bus.ab_valid !== 1'b0 ||
        bus.c_row !== '0 || bus.a_out !== '0 || bus.b_out !== '0)
    begin
      miscompares++;
      $display("FAIL reset_outputs: got cir=%b busy=%b abr=%b cv=%b rv=%b abv=%b want 1 1 0 0 0 0 and zero data",
               bus.c_in_ready, bus.busy, bus.ab_in_ready, bus.c_valid, bus.c_row_vld, bus.ab_valid);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.c_in_ready !== 1'b1 || bus.busy !== 1'b1 || bus.ab_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_fill: got cir=%b busy=%b abr=%b want 1 1 0",
               bus.c_in_ready, bus.busy, bus.ab_in_ready);
    end
  endtask

  // Offer a tile, then expect c_valid the cycle after the last accept and the rows in order.
  task automatic load_tile(input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    logic [DW-1:0] rows [ML];
    int acc = 0;
    int cyc = 0;
    rows[0] = r0;
    rows[1] = r1;
    while (acc < ML && cyc < 40) begin
      bus.c_in_valid = 1'b1;
      bus.c_in_data  = rows[acc];
      vectors++;
      if (bus.c_valid !== 1'b0 || bus.c_row_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL tile_early_c: got cv=%b rv=%b want 0 0", bus.c_valid, bus.c_row_vld);
      end
      if (bus.c_in_ready === 1'b1) acc++;
      tick();
      cyc++;
    end
    bus.c_in_valid = 1'b0;
    vectors++;
    if (acc < ML) begin
      miscompares++;
      $display("FAIL tile_accept_timeout: got %0d rows accepted want %0d", acc, ML);
      return;
    end
    vectors++;
    if (bus.c_valid !== 1'b1 || bus.c_row_vld !== 1'b0 || bus.c_in_ready !== 1'b0 ||
        bus.ab_in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.ab_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tile_c_valid: got cv=%b rv=%b cir=%b abr=%b busy=%b abv=%b want 1 0 0 0 1 0",
               bus.c_valid, bus.c_row_vld, bus.c_in_ready, bus.ab_in_ready, bus.busy, bus.ab_valid);
    end
    tick();
    for (int k = 0; k < ML; k++) begin
      vectors++;
      if (bus.c_row_vld !== 1'b1 || bus.c_row !== rows[k] || bus.c_valid !== 1'b0 ||
          bus.ab_valid !== 1'b0 || bus.c_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL tile_row%0d: got rv=%b row=%h cv=%b abv=%b want 1 %h 0 0",
                 k, bus.c_row_vld, bus.c_row, bus.c_valid, bus.ab_valid, rows[k]);
      end
      tick();
    end
    vectors++;
    if (bus.c_row_vld !== 1'b0 || bus.c_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.ab_in_ready !== 1'b1 || bus.c_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tile_enter_run: got rv=%b cv=%b busy=%b abr=%b cir=%b want 0 0 0 1 0",
               bus.c_row_vld, bus.c_valid, bus.busy, bus.ab_in_ready, bus.c_in_ready);
    end
  endtask

  // Reference: FIFO occupancy plus an in-order queue; a pair leaves the queue every
  // cycle the occupancy is non-zero and shows up on a_out/b_out one cycle later.
  task automatic run_pairs(input int n, input int gap_pct);
    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] pend_d = '0;
    logic [DW-1:0]   a, b;
    int mcount = 0;
    int pushed = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit v, pu, po;
    while (cyc < 400) begin
      vectors++;
      if (bus.ab_valid !== pend) begin
        miscompares++;
        $display("FAIL ab_valid: got %b want %b (cycle %0d)", bus.ab_valid, pend, cyc);
      end else if (pend && {bus.a_out, bus.b_out} !== pend_d) begin
        miscompares++;
        $display("FAIL ab_data: got a=%h b=%h want a=%h b=%h",
                 bus.a_out, bus.b_out, pend_d[2*DW-1:DW], pend_d[DW-1:0]);
      end
      if (bus.ab_in_ready !== (mcount < ABD)) begin
        miscompares++;
        $display("FAIL ab_in_ready: got %b want %b", bus.ab_in_ready, (mcount < ABD));
      end
      if (bus.busy !== (mcount != 0)) begin
        miscompares++;
        $display("FAIL run_busy: got %b want %b", bus.busy, (mcount != 0));
      end
      if (bus.c_valid !== 1'b0 || bus.c_row_vld !== 1'b0 || bus.c_in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL run_c_quiet: got cv=%b rv=%b cir=%b want 0 0 0",
                 bus.c_valid, bus.c_row_vld, bus.c_in_ready);
      end
      if (pushed == n && mcount == 0 && !pend) break;
      v = (pushed < n) && ($urandom_range(99) >= gap_pct);
      a = rnd64();
      b = rnd64();
      bus.ab_in_valid = v;
      bus.ab_in_a     = a;
      bus.ab_in_b     = b;
      pu = v && (mcount < ABD);
      po = (mcount > 0);
      pend = po;
      if (po) pend_d = q.pop_front();
      if (pu) begin
        q.push_back({a, b});
        pushed++;
      end
      mcount = mcount + int'(pu) - int'(po);
      tick();
      cyc++;
    end
    bus.ab_in_valid = 1'b0;
    vectors++;
    if (cyc >= 400) begin
      miscompares++;
      $display("FAIL pairs_timeout: got %0d of %0d pairs pushed, occupancy %0d", pushed, n, mcount);
    end
  endtask

  task automatic test_c_load();
    load_tile(64'hA0, 64'hA1);
  endtask

  task automatic test_back_to_back();
    run_pairs(ABD, 0);
  endtask

  task automatic test_hold_valid();
    run_pairs(12, 0);
  endtask

  task automatic test_random_pairs();
    run_pairs(24, 40);
  endtask

  task automatic test_c_after_ab();
    logic [2*DW-1:0] q[$];
    logic [2*DW-1:0] exp_d;
    logic [DW-1:0]   a, b;
    int seen = 0;
    int cyc = 0;
    for (int i = 0; i < 2; i++) begin
      a = rnd64();
      b = rnd64();
      bus.ab_in_valid = 1'b1;
      bus.ab_in_a     = a;
      bus.ab_in_b     = b;
      vectors++;
      if (bus.ab_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL c_after_ab_push%0d: got ready %b want 1", i, bus.ab_in_ready);
      end
      q.push_back({a, b});
      tick();
    end
    bus.ab_in_valid = 1'b0;
    bus.c_in_valid  = 1'b1;
    bus.c_in_data   = 64'hC0;
    while (seen < 2 && cyc < 20) begin
      vectors++;
      if (bus.c_in_ready !== 1'b0 || bus.c_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL c_before_ab: got cir=%b cv=%b with %0d pairs issued, want 0 0", bus.c_in_ready, bus.c_valid, seen);
      end
      if (bus.ab_valid === 1'b1) begin
        exp_d = (q.size() > 0) ? q.pop_front() : '0;
        if ({bus.a_out, bus.b_out} !== exp_d) begin
          miscompares++;
          $display("FAIL c_after_ab_data: got %h%h want %h", bus.a_out, bus.b_out, exp_d);
        end
        seen++;
      end
      if (seen < 2) begin
        tick();
        cyc++;
      end
    end
    vectors++;
    if (seen < 2) begin
      miscompares++;
      $display("FAIL c_after_ab_timeout: got %0d ab_valid want 2", seen);
    end
    load_tile(64'hC0, 64'hC1);
  endtask

  task automatic test_both_valid();
    logic [DW-1:0] a, b;
    a = rnd64();
    b = rnd64();
    bus.ab_in_valid = 1'b1;
    bus.ab_in_a     = a;
    bus.ab_in_b     = b;
    bus.c_in_valid  = 1'b1;
    bus.c_in_data   = 64'hDEAD;
    vectors++;
    if (bus.ab_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL both_ready: got %b want 1", bus.ab_in_ready);
    end
    tick();
    bus.ab_in_valid = 1'b0;
    bus.c_in_valid  = 1'b0;
    vectors++;
    if (bus.c_in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.ab_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL both_queued: got cir=%b busy=%b abv=%b want 0 1 0", bus.c_in_ready, bus.busy, bus.ab_valid);
    end
    tick();
    vectors++;
    if (bus.ab_valid !== 1'b1 || bus.a_out !== a || bus.b_out !== b || bus.c_in_ready !== 1'b0 ||
        bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL both_issue: got abv=%b a=%h b=%h cir=%b busy=%b want 1 %h %h 0 0",
               bus.ab_valid, bus.a_out, bus.b_out, bus.c_in_ready, bus.busy, a, b);
    end
    tick();
    vectors++;
    if (bus.ab_valid !== 1'b0 || bus.c_in_ready !== 1'b0 || bus.ab_in_ready !== 1'b1 || bus.c_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL both_stay_run: got abv=%b cir=%b abr=%b cv=%b want 0 0 1 0",
               bus.ab_valid, bus.c_in_ready, bus.ab_in_ready, bus.c_valid);
    end
  endtask

  task automatic test_reset_in_shift();
    logic [DW-1:0] r0, r1;
    int acc = 0;
    int cyc = 0;
    r0 = rnd64();
    r1 = rnd64();
    while (acc < ML && cyc < 40) begin
      bus.c_in_valid = 1'b1;
      bus.c_in_data  = (acc == 0) ? r0 : r1;
      if (bus.c_in_ready === 1'b1) acc++;
      tick();
      cyc++;
    end
    bus.c_in_valid = 1'b0;
    vectors++;
    if (acc < ML || bus.c_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_shift_setup: got %0d rows, cv=%b want %0d rows, cv=1", acc, bus.c_valid, ML);
    end
    tick();
    vectors++;
    if (bus.c_row_vld !== 1'b1 || bus.c_row !== r0) begin
      miscompares++;
      $display("FAIL rst_shift_row0: got rv=%b row=%h want 1 %h", bus.c_row_vld, bus.c_row, r0);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.c_row_vld !== 1'b0 || bus.c_valid !== 1'b0 || bus.c_in_ready !== 1'b1 ||
        bus.busy !== 1'b1 || bus.ab_in_ready !== 1'b0 || bus.c_row !== '0) begin
      miscompares++;
      $display("FAIL rst_shift_async: got rv=%b cv=%b cir=%b busy=%b abr=%b want 0 0 1 1 0",
               bus.c_row_vld, bus.c_valid, bus.c_in_ready, bus.busy, bus.ab_in_ready);
    end
    #1;
    reset = 1'b0;
    tick();
    load_tile(rnd64(), rnd64());
  endtask

  initial begin
    bus.c_in_valid  = 1'b0;
    bus.c_in_data   = '0;
    bus.ab_in_valid = 1'b0;
    bus.ab_in_a     = '0;
    bus.ab_in_b     = '0;
    #12;
    test_reset();
    test_c_load();
    test_back_to_back();
    test_hold_valid();
    test_random_pairs();
    test_c_after_ab();
    test_both_valid();
    test_reset_in_shift();
    for (int t = 0; t < 3; t++) begin
      run_pairs($urandom_range(10, 1), 30);
      load_tile(rnd64(), rnd64());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
